count_seq_monitor: RTL
======================

// Module: count_seq_monitor
// PURPOSE
//  Synchronous checker downstream of the ripple mod-2^CNT_W counter (clk/reset domain).
//  Samples the asynchronous ripple count, filters ripple transients, and verifies that
//  every accepted change is exactly +1 mod 2^CNT_W. Flags upsets and counts them for SEU
//  characterisation of hardened flops. Emits step/wrap pulses for downstream logic.
// PARAMETERS
//  CNT_W        2  width of monitored count (modulus 2^CNT_W)
//  SYNC_STAGES  2  synchroniser depth on cnt_in, >=2
//  ERR_W        8  width of saturating error counter
// PORTS
//  clk       in   1      system clock, all state on rising edge
//  reset     in   1      synchronous, active-high reset
//  cnt_in    in   CNT_W  ripple counter output, asynchronous to clk
//  clr_err   in   1      synchronous clear of err_cnt and err_flag
//  locked    out  1      reference captured, checking active
//  step      out  1      1-cycle pulse: valid +1 step accepted
//  wrap      out  1      1-cycle pulse: valid step max->0 accepted (step also high)
//  err_pulse out  1      1-cycle pulse: illegal transition accepted
//  err_flag  out  1      sticky, set on any error
//  err_cnt   out  ERR_W  saturating error count
//  ref_cnt   out  CNT_W  last accepted count value
// BEHAVIOUR
//  - Reset (reset=1 at edge): all sync/filter regs 0, state INIT; locked=0, step=0,
//    wrap=0, err_pulse=0, err_flag=0, err_cnt=0, ref_cnt=0. Reset wins over all inputs.
//  - Sync: s[0]<=cnt_in, s[i]<=s[i-1]; prev<=s[N-1]. Sample is "stable" when s[N-1]==prev.
//    Unstable samples are ignored (absorbs 1->0->2 ripple glitch).
//  - States (enum): INIT, TRACK.
//    INIT: first stable sample -> ref_cnt<=sample, locked<=1, ->TRACK. No pulses.
//    TRACK: stable sample == ref_cnt -> no action.
//      stable sample == ref_cnt+1 mod 2^CNT_W -> ref_cnt<=sample, step pulse;
//        wrap pulse also if ref_cnt==2^CNT_W-1.
//      any other stable sample -> err_pulse, err_flag<=1, err_cnt<=sat(err_cnt+1),
//        ref_cnt<=sample (resync; next check relative to new value).
//  - Latency: cnt_in settles before edge k -> pulse outputs high in cycle after edge
//    k+SYNC_STAGES+1 (3 edges with defaults). All outputs registered.
//  - Pulses last exactly one cycle; at most one accepted event per cycle.
//  - err_cnt saturates at 2^ERR_W-1; further errors keep it there, still pulse err_pulse.
//  - clr_err alone: err_cnt<=0, err_flag<=0. clr_err same cycle as error: error counted
//    after clear -> err_cnt=1, err_flag=1.
//  - Reset mid-operation: returns to INIT; first stable value after reset is not checked.
// CONFIGURATION
//  COUNT_SEQ_MONITOR_WRAPCNT_EN defined: extra port wrap_cnt out ERR_W, saturating count of
//   wrap pulses, 0 on reset, cleared by clr_err (same priority rule as err_cnt).
//  Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  - count_mon_pkg: state enum {INIT, TRACK}, function next_cnt(v) = v+1 mod 2^CNT_W,
//    saturating-increment helper.
//  - One sub-module: sync_chain (parameterised SYNC_STAGES x CNT_W flop chain, sync reset).
//  - Top: filter compare, FSM, error/wrap counters.
// TESTING
//  1 reset, cnt_in held 2 -> locked=1 after 3 edges, ref_cnt=2, no step/err pulses.
//  2 drive 0,1,2,3,0 each held 4 cycles -> 4 step pulses, 1 wrap on 3->0, err_cnt=0.
//  3 ripple glitch 1->0 (1 cycle)->2 -> single step, no err_pulse, ref_cnt=2.
//  4 jump 1->3 -> err_pulse, err_flag=1, err_cnt=1, ref_cnt=3; then 3->0 gives step+wrap.
//  5 force 300 illegal jumps (ERR_W=8) -> err_cnt=255 saturated; clr_err with error same
//    cycle -> err_cnt=1, err_flag=1.
//  6 reset asserted mid-TRACK with cnt_in=3 -> all outputs 0, re-lock to 3 unchecked;
//    repeat 2 with COUNT_SEQ_MONITOR_WRAPCNT_EN -> wrap_cnt=1.

Source files
------------

// File: rtl/count_mon_pkg.sv
// Shared types and helpers for the count sequence monitor.
// State encoding plus width-generic modular and saturating increment helpers.
package count_mon_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        TRACK = 1'b1
    } state_t;

    // All-ones mask for a field of width w (w up to 32)
    function automatic logic [31:0] width_mask(input int unsigned w);
        logic [31:0] mask;
        if (w >= 32) begin
            mask = '1;
        end else begin
            mask = (32'd1 << w) - 32'd1;
        end
        return mask;
    endfunction

    // Next value of a w-bit up counter, wrapping modulo 2^w
    function automatic logic [31:0] next_cnt(input logic [31:0] v, input int unsigned w);
        return (v + 32'd1) & width_mask(w);
    endfunction

    // w-bit increment that sticks at all-ones
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] mask;
        mask = width_mask(w);
        if (v >= mask) begin
            return mask;
        end
        return v + 32'd1;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a bus sampled from another timing domain.
// Every stage clears on synchronous reset so post-reset history starts clean.
module sync_chain #(
    parameter int STAGES = 2,
    parameter int W      = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage_reg [STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                // First stage captures the asynchronous input
                always_ff @(posedge clk) begin
                    if (reset) begin
                        stage_reg[0] <= '0;
                    end else begin
                        stage_reg[0] <= d;
                    end
                end
            end else begin : g_next
                // Later stages shift the sample down the chain
                always_ff @(posedge clk) begin
                    if (reset) begin
                        stage_reg[gi] <= '0;
                    end else begin
                        stage_reg[gi] <= stage_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/count_seq_monitor.sv
// Synchronous checker for a ripple counter running asynchronously to clk.
// Synchronises the count, drops samples that differ from the previous one
// (ripple transients), and checks each accepted change is +1 modulo 2^CNT_W.
// Optional build macro COUNT_SEQ_MONITOR_WRAPCNT_EN adds a saturating
// wrap counter output (wrap_cnt), cleared by clr_err like err_cnt.
module count_seq_monitor
    import count_mon_pkg::*;
#(
    parameter int CNT_W       = 2,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] cnt_in,
    input  logic             clr_err,
    output logic             locked,
    output logic             step,
    output logic             wrap,
    output logic             err_pulse,
    output logic             err_flag,
    output logic [ERR_W-1:0] err_cnt,
`ifdef COUNT_SEQ_MONITOR_WRAPCNT_EN
    output logic [ERR_W-1:0] wrap_cnt,
`endif
    output logic [CNT_W-1:0] ref_cnt
);

    // A sample is only trusted once the chain and prev register hold post-reset data
    localparam int FILL_MAX = SYNC_STAGES + 1;
    localparam int FILL_W   = $clog2(FILL_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]  sample;
    logic [CNT_W-1:0]  prev_reg;
    logic [FILL_W-1:0] fill_reg;
    logic              primed;
    logic              stable;

    state_t            state_reg;
    logic              locked_reg;
    logic              step_reg;
    logic              wrap_reg;
    logic              err_pulse_reg;
    logic [CNT_W-1:0]  ref_cnt_reg;
    logic              err_flag_reg;
    logic              err_flag_next;
    logic [ERR_W-1:0]  err_cnt_reg;
    logic [ERR_W-1:0]  err_cnt_next;
    logic [ERR_W-1:0]  err_base;

    logic [CNT_W-1:0]  ref_plus1;
    logic              is_step;
    logic              is_wrap;
    logic              is_err;

    sync_chain #(
        .STAGES (SYNC_STAGES),
        .W      (CNT_W)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (cnt_in),
        .q     (sample)
    );

    // Previous synchronised sample and post-reset fill tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_reg <= '0;
            fill_reg <= '0;
        end else begin
            prev_reg <= sample;
            if (fill_reg != FILL_W'(FILL_MAX)) begin
                fill_reg <= fill_reg + FILL_W'(1);
            end
        end
    end

    assign primed    = (fill_reg == FILL_W'(FILL_MAX));
    assign stable    = primed && (sample == prev_reg);
    assign ref_plus1 = CNT_W'(next_cnt(32'(ref_cnt_reg), CNT_W));

    // Classify the stable sample against the reference while tracking
    always_comb begin
        is_step = 1'b0;
        is_wrap = 1'b0;
        is_err  = 1'b0;
        if (stable && state_reg == TRACK) begin
            if (sample == ref_plus1) begin
                is_step = 1'b1;
                is_wrap = (ref_cnt_reg == CNT_MAX);
            end else if (sample != ref_cnt_reg) begin
                is_err = 1'b1;
            end
        end
    end

    // Lock/track FSM with registered pulse outputs and reference value
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= INIT;
            locked_reg    <= 1'b0;
            ref_cnt_reg   <= '0;
            step_reg      <= 1'b0;
            wrap_reg      <= 1'b0;
            err_pulse_reg <= 1'b0;
        end else begin
            step_reg      <= 1'b0;
            wrap_reg      <= 1'b0;
            err_pulse_reg <= 1'b0;
            case (state_reg)
                INIT: begin
                    if (stable) begin
                        ref_cnt_reg <= sample;
                        locked_reg  <= 1'b1;
                        state_reg   <= TRACK;
                    end
                end
                TRACK: begin
                    if (is_step) begin
                        ref_cnt_reg <= sample;
                        step_reg    <= 1'b1;
                        wrap_reg    <= is_wrap;
                    end else if (is_err) begin
                        // Resync so the next check is relative to the new value
                        ref_cnt_reg   <= sample;
                        err_pulse_reg <= 1'b1;
                    end
                end
                default: state_reg <= INIT;
            endcase
        end
    end

    // Clear applies first, so an error in the same cycle still counts
    always_comb begin
        err_base      = clr_err ? '0 : err_cnt_reg;
        err_cnt_next  = is_err ? ERR_W'(sat_inc(32'(err_base), ERR_W)) : err_base;
        err_flag_next = is_err | (~clr_err & err_flag_reg);
    end

    // Sticky error flag and saturating error count
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_reg  <= '0;
            err_flag_reg <= 1'b0;
        end else begin
            err_cnt_reg  <= err_cnt_next;
            err_flag_reg <= err_flag_next;
        end
    end

`ifdef COUNT_SEQ_MONITOR_WRAPCNT_EN
    logic [ERR_W-1:0] wrap_cnt_reg;
    logic [ERR_W-1:0] wrap_base;
    logic [ERR_W-1:0] wrap_cnt_next;

    // Same clear-then-count priority as the error counter
    always_comb begin
        wrap_base     = clr_err ? '0 : wrap_cnt_reg;
        wrap_cnt_next = is_wrap ? ERR_W'(sat_inc(32'(wrap_base), ERR_W)) : wrap_base;
    end

    // Saturating count of accepted wrap steps
    always_ff @(posedge clk) begin
        if (reset) begin
            wrap_cnt_reg <= '0;
        end else begin
            wrap_cnt_reg <= wrap_cnt_next;
        end
    end

    assign wrap_cnt = wrap_cnt_reg;
`else
    // Wrap counter is not built; wraps are reported only by the wrap pulse
`endif

    assign locked    = locked_reg;
    assign step      = step_reg;
    assign wrap      = wrap_reg;
    assign err_pulse = err_pulse_reg;
    assign err_flag  = err_flag_reg;
    assign err_cnt   = err_cnt_reg;
    assign ref_cnt   = ref_cnt_reg;

endmodule
